// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_pkg : shared types and op-decode helpers for muldiv_unit      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_if : request/response bundle between EX stage and muldiv_unit |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface muldiv_if #(
  parameter int XLEN = 32
) ();
  import muldiv_pkg::*;

  logic            start;
  op_e             op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, a, b, kill, input busy, done, result);
  modport slave  (input start, op, a, b, kill, output busy, done, result);

endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_step : one shift-add (mul) or restoring-subtract (div) bit    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] d,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_sub;
  logic            w_ge;

  always_comb begin
    w_sum   = {1'b0, hi_in} + (lo_in[0] ? {1'b0, d} : '0);
    w_shift = {hi_in, lo_in[XLEN-1]};
    w_ge    = (w_shift >= {1'b0, d});
    // When w_ge holds the difference is below d, so the low XLEN bits are exact.
    w_sub   = w_shift[XLEN-1:0] - d;
    if (is_div) begin
      hi_out = w_ge ? w_sub : w_shift[XLEN-1:0];
      lo_out = {lo_in[XLEN-2:0], w_ge};
    end else begin
      hi_out = w_sum[XLEN:1];
      lo_out = {w_sum[0], lo_in[XLEN-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_unit : iterative RV32M multiply/divide unit for the EX stage  |
// | Optional: MULDIV_REM_FUSE_EN reuses a finished DIV for REM and back. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  import muldiv_pkg::*;

  localparam int ITER  = XLEN / UNROLL;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_e            r_state;
  state_e            w_state_nxt;
  op_e               r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_d;
  logic [XLEN-1:0]   r_result;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_special;
  logic              r_fused;

  logic              w_busy;
  logic              w_accept;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_b_zero;
  logic              w_special;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;
  logic [XLEN-1:0]   w_hi_nxt;
  logic [XLEN-1:0]   w_lo_nxt;
  logic              w_fuse_hit;
  logic [XLEN-1:0]   w_fuse_q;
  logic [XLEN-1:0]   w_fuse_r;

  assign w_busy     = (r_state == ST_PREP) || (r_state == ST_CALC) || (r_state == ST_FIX);
  assign w_accept   = (r_state == ST_IDLE) && bus.start && !bus.kill;
  assign bus.busy   = w_busy;
  assign bus.done   = (r_state == ST_DONE);
  assign bus.result = r_result;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_fuse_hit ? ST_FIX : ST_PREP;
      ST_PREP: w_state_nxt = w_special ? ST_FIX : ST_CALC;
      ST_CALC: if (r_cnt == '0) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (bus.kill && w_busy) w_state_nxt = ST_IDLE;
  end

  // ---------------------------------------------------------------- operand conditioning
  always_comb begin
    w_sa      = is_signed_a(r_op) && r_a[XLEN-1];
    w_sb      = is_signed_b(r_op) && r_b[XLEN-1];
    w_mag_a   = w_sa ? -r_a : r_a;
    w_mag_b   = w_sb ? -r_b : r_b;
    w_b_zero  = (r_b == '0);
    // Only signed division can overflow: most-negative / -1.
    w_special = is_div(r_op) && (w_b_zero ||
                (is_signed_a(r_op) && (r_a == {1'b1, {(XLEN-1){1'b0}}}) && (r_b == '1)));
  end

  // ---------------------------------------------------------------- iteration chain
  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
    logic [XLEN-1:0] hi_in;
    logic [XLEN-1:0] lo_in;
    logic [XLEN-1:0] hi_out;
    logic [XLEN-1:0] lo_out;
    if (gi == 0) begin : g_first
      assign hi_in = r_hi;
      assign lo_in = r_lo;
    end else begin : g_chain
      assign hi_in = g_step[gi-1].hi_out;
      assign lo_in = g_step[gi-1].lo_out;
    end
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div (is_div(r_op)),
      .d      (r_d),
      .hi_in  (hi_in),
      .lo_in  (lo_in),
      .hi_out (hi_out),
      .lo_out (lo_out)
    );
  end

  assign w_hi_nxt = g_step[UNROLL-1].hi_out;
  assign w_lo_nxt = g_step[UNROLL-1].lo_out;

  // ---------------------------------------------------------------- result fix-up
  always_comb begin
    w_prod   = {r_hi, r_lo};
    w_prod_s = r_neg_q ? -w_prod : w_prod;
    if (r_fused) begin
      w_quot = w_fuse_q;
      w_rem  = w_fuse_r;
    end else if (r_special) begin
      w_quot = w_b_zero ? '1  : r_a;
      w_rem  = w_b_zero ? r_a : '0;
    end else begin
      w_quot = r_neg_q ? -r_lo : r_lo;
      w_rem  = r_neg_r ? -r_hi : r_hi;
    end
    case (r_op)
      OP_MUL:                       w_fix_res = w_prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_fix_res = w_quot;
      default:                      w_fix_res = w_rem;
    endcase
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= OP_MUL;
      r_a       <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_d       <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
      r_fused   <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= bus.op;
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_fused <= w_fuse_hit;
          end
        end
        ST_PREP: begin
          r_hi      <= '0;
          r_lo      <= is_div(r_op) ? w_mag_a : w_mag_b;
          r_d       <= is_div(r_op) ? w_mag_b : w_mag_a;
          r_cnt     <= CNT_W'(ITER - 1);
          r_neg_q   <= w_sa ^ w_sb;
          r_neg_r   <= w_sa;
          r_special <= w_special;
        end
        ST_CALC: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        ST_FIX: begin
          if (!bus.kill) r_result <= w_fix_res;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- DIV/REM fusion
`ifdef MULDIV_REM_FUSE_EN
  logic            r_fv;
  op_e             r_fop;
  logic [XLEN-1:0] r_fa;
  logic [XLEN-1:0] r_fb;
  logic [XLEN-1:0] r_fq;
  logic [XLEN-1:0] r_fr;

  // Complementary op differs only in bit 1 (DIV<->REM, DIVU<->REMU).
  assign w_fuse_hit = r_fv && is_div(bus.op) && (bus.op == (r_fop ^ 3'b010)) &&
                      (bus.a == r_fa) && (bus.b == r_fb);
  assign w_fuse_q   = r_fq;
  assign w_fuse_r   = r_fr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fv  <= 1'b0;
      r_fop <= OP_MUL;
      r_fa  <= '0;
      r_fb  <= '0;
      r_fq  <= '0;
      r_fr  <= '0;
    end else if (w_accept && !is_div(bus.op)) begin
      r_fv <= 1'b0;
    end else if (w_busy && bus.kill) begin
      r_fv <= 1'b0;
    end else if ((r_state == ST_FIX) && is_div(r_op)) begin
      r_fv  <= 1'b1;
      r_fop <= r_op;
      r_fa  <= r_a;
      r_fb  <= r_b;
      r_fq  <= w_quot;
      r_fr  <= w_rem;
    end
  end
`else
  assign w_fuse_hit = 1'b0;
  assign w_fuse_q   = '0;
  assign w_fuse_r   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muldiv_unit : directed vector bench for muldiv_unit (XLEN=32)     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN     = 32;
  localparam int NORM_LAT = 35;
  localparam int SPEC_LAT = 3;
  localparam int MAXC     = 60;
`ifdef MULDIV_REM_FUSE_EN
  localparam int FUSE_LAT = 2;
`else
  localparam int FUSE_LAT = NORM_LAT;
`endif

  logic clk = 1'b0;
  logic rst;

  muldiv_if #(.XLEN(XLEN)) bus_if ();

  muldiv_unit #(.XLEN(XLEN), .UNROLL(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Cycle 0 is the start cycle; abort_cyc >= 0 pulses kill (or rst) in that cycle.
  task automatic run_op(input op_e o, input logic [31:0] av, input logic [31:0] bv,
                        input int abort_cyc, input bit use_rst,
                        output bit got_done, output int lat, output logic [31:0] res,
                        output bit bad_hs, output logic busy_after);
    got_done   = 1'b0;
    lat        = 0;
    res        = '0;
    bad_hs     = 1'b0;
    busy_after = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = o;
    bus_if.a     = av;
    bus_if.b     = bv;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.a     = $urandom;
    bus_if.b     = $urandom;
    bus_if.op    = op_e'(3'($urandom_range(0, 7)));
    for (int n = 1; n <= MAXC; n++) begin
      if (n == abort_cyc + 1) busy_after = bus_if.busy;
      if (bus_if.done) begin
        if (bus_if.busy) bad_hs = 1'b1;
        got_done = 1'b1;
        lat      = n;
        res      = bus_if.result;
        break;
      end else if (!bus_if.busy && (abort_cyc < 0 || n <= abort_cyc)) begin
        bad_hs = 1'b1;
      end
      if (n == abort_cyc) begin
        if (use_rst) rst = 1'b1;
        else         bus_if.kill = 1'b1;
      end
      if (n == abort_cyc + 1) begin
        rst         = 1'b0;
        bus_if.kill = 1'b0;
      end
      @(negedge clk);
    end
    if (got_done) begin
      @(negedge clk);
      if (bus_if.done || bus_if.busy) bad_hs = 1'b1;
    end
  endtask

  initial begin
    bit          gd;
    bit          bad;
    int          lat;
    logic [31:0] res;
    logic        ba;

    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.kill  = 1'b0;
    bus_if.op    = OP_MUL;
    bus_if.a     = '0;
    bus_if.b     = '0;

    vecs[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, NORM_LAT};
    vecs[1]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, NORM_LAT};
    vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, NORM_LAT};
    vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, NORM_LAT};
    vecs[4]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, NORM_LAT};
    vecs[5]  = '{OP_DIVU,   32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, NORM_LAT};
    vecs[6]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, NORM_LAT};
    vecs[7]  = '{OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, SPEC_LAT};
    vecs[8]  = '{OP_MUL,    32'd3,        32'd4,        32'd12,       NORM_LAT};
    vecs[9]  = '{OP_REM,    32'd5,        32'd0,        32'd5,        SPEC_LAT};
    vecs[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPEC_LAT};
    vecs[11] = '{OP_MULHU,  32'hFFFFFFFF, 32'd2,        32'd1,        NORM_LAT};
    vecs[12] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        SPEC_LAT};
    vecs[13] = '{OP_DIV,    32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, NORM_LAT};
    vecs[14] = '{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, SPEC_LAT};
    vecs[15] = '{OP_MULH,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, NORM_LAT};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",   {31'd0, bus_if.busy}, 32'd0);
    check("reset_done",   {31'd0, bus_if.done}, 32'd0);
    check("reset_result", bus_if.result,        32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, 1'b0, gd, lat, res, bad, ba);
      check($sformatf("vec%0d_result", i),    res,           vecs[i].exp);
      check($sformatf("vec%0d_latency", i),   32'(lat),      32'(vecs[i].lat));
      check($sformatf("vec%0d_handshake", i), {31'd0, bad},  32'd0);
    end

    // Abort by kill in CALC, then a fresh op runs the full path.
    run_op(OP_DIVU, 32'd100, 32'd3, 10, 1'b0, gd, lat, res, bad, ba);
    check("kill_no_done",     {31'd0, gd},  32'd0);
    check("kill_busy_before", {31'd0, bad}, 32'd0);
    check("kill_busy_after",  {31'd0, ba},  32'd0);
    check("kill_result_held", bus_if.result, 32'hFFFFFFFF);
    run_op(OP_REMU, 32'd100, 32'd3, -1, 1'b0, gd, lat, res, bad, ba);
    check("kill_next_result",  res,      32'd1);
    check("kill_next_latency", 32'(lat), 32'(NORM_LAT));

    // Same scenario with a synchronous reset.
    run_op(OP_DIVU, 32'd100, 32'd3, 10, 1'b1, gd, lat, res, bad, ba);
    check("rst_no_done",      {31'd0, gd},  32'd0);
    check("rst_busy_after",   {31'd0, ba},  32'd0);
    check("rst_result_clear", bus_if.result, 32'd0);
    run_op(OP_REMU, 32'd100, 32'd3, -1, 1'b0, gd, lat, res, bad, ba);
    check("rst_next_result",  res,      32'd1);
    check("rst_next_latency", 32'(lat), 32'(NORM_LAT));

    // start together with kill in IDLE is dropped.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.kill  = 1'b1;
    bus_if.op    = OP_MUL;
    bus_if.a     = 32'd9;
    bus_if.b     = 32'd9;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.kill  = 1'b0;
    check("start_kill_busy", {31'd0, bus_if.busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("start_kill_done",   {31'd0, bus_if.done}, 32'd0);
    check("start_kill_result", bus_if.result,        32'd1);

    // DIV/REM reuse sequence; a multiply in between forces the full path.
    run_op(OP_DIV, 32'd100, 32'd7, -1, 1'b0, gd, lat, res, bad, ba);
    check("fuse_div_result",  res,      32'd14);
    check("fuse_div_latency", 32'(lat), 32'(NORM_LAT));
    run_op(OP_REM, 32'd100, 32'd7, -1, 1'b0, gd, lat, res, bad, ba);
    check("fuse_rem_result",  res,      32'd2);
    check("fuse_rem_latency", 32'(lat), 32'(FUSE_LAT));
    check("fuse_rem_hs",      {31'd0, bad}, 32'd0);
    run_op(OP_MUL, 32'd100, 32'd7, -1, 1'b0, gd, lat, res, bad, ba);
    check("fuse_mul_result",  res,      32'h000002BC);
    run_op(OP_REM, 32'd100, 32'd7, -1, 1'b0, gd, lat, res, bad, ba);
    check("fuse_rem2_result",  res,      32'd2);
    check("fuse_rem2_latency", 32'(lat), 32'(NORM_LAT));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
